// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle fetch/execute control unit for the 8-bit datapath. It holds
//   the program counter and the instruction register, fetches 16-bit
//   instructions with a ready handshake, and decodes the instruction register
//   into the datapath control word. Jumps and conditional branches are
//   resolved from the datapath status flags and jumpAddress.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   instrAddress          instruction memory address (always the PC)
//   instrIn, instrReady   instruction word and its valid strobe
//   V, C, N, Z            datapath status, same cycle (only N and Z are used)
//   jumpAddress           datapath R[AA], the JMP target
//   RW, DA, AA, BA        register write enable and register addresses
//   MB, MD, FS            B-source select, memory-data select, function select
//   constantOut           immediate driven onto the datapath constant input
//   MW                    data memory write enable
//   halted                high while the sequencer sits in HALT
module control_sequencer #(
  parameter int         size     = 8,
  parameter logic [3:0] FS_ADD   = 4'b0010,
  parameter logic [3:0] FS_PASSA = 4'b0000,
  parameter logic [3:0] FS_PASSB = 4'b1100
) (
  input  logic            clk,
  input  logic            reset,
  output logic [size-1:0] instrAddress,
  input  logic [15:0]     instrIn,
  input  logic            instrReady,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  input  logic [size-1:0] jumpAddress,
  output logic            RW,
  output logic [1:0]      DA,
  output logic [1:0]      AA,
  output logic [1:0]      BA,
  output logic            MB,
  output logic            MD,
  output logic [3:0]      FS,
  output logic [size-1:0] constantOut,
  output logic            MW,
  output logic            halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } stateT;

  localparam logic [3:0] opNop  = 4'd0;
  localparam logic [3:0] opOpr  = 4'd1;
  localparam logic [3:0] opAddi = 4'd2;
  localparam logic [3:0] opLdi  = 4'd3;
  localparam logic [3:0] opLd   = 4'd4;
  localparam logic [3:0] opSt   = 4'd5;
  localparam logic [3:0] opJmp  = 4'd6;
  localparam logic [3:0] opBrz  = 4'd7;
  localparam logic [3:0] opHalt = 4'd8;
  localparam logic [3:0] opBrn  = 4'd9;

  stateT           stateReg;
  logic [size-1:0] pcReg;
  logic [15:0]     irReg;
  logic            haltedReg;

  logic [3:0]      opcode;
  logic [size-1:0] immExt;
  logic [size-1:0] branchTarget;

  // Overflow and carry play no part in branching.
  logic unusedFlags;
  assign unusedFlags = V ^ C;

  assign opcode = irReg[15:12];
  // Branch offset is a signed byte; the PC already points past the branch.
  assign immExt       = size'($signed(irReg[7:0]));
  assign branchTarget = pcReg + immExt;

  assign instrAddress = pcReg;
  assign halted       = haltedReg;

  // Control word is combinational from state and IR so it is stable for the
  // whole EXEC cycle; the datapath commits on the edge that ends EXEC.
  always_comb begin
    RW          = 1'b0;
    DA          = 2'b00;
    AA          = 2'b00;
    BA          = 2'b00;
    MB          = 1'b0;
    MD          = 1'b0;
    FS          = 4'b0000;
    constantOut = '0;
    MW          = 1'b0;
    if (stateReg == EXEC) begin
      case (opcode)
        opOpr: begin
          RW = 1'b1;
          DA = irReg[11:10];
          AA = irReg[9:8];
          BA = irReg[7:6];
          FS = irReg[3:0];
        end
        opAddi: begin
          RW          = 1'b1;
          DA          = irReg[11:10];
          AA          = irReg[9:8];
          MB          = 1'b1;
          FS          = FS_ADD;
          constantOut = size'(irReg[7:0]);
        end
        opLdi: begin
          RW          = 1'b1;
          DA          = irReg[11:10];
          MB          = 1'b1;
          FS          = FS_PASSB;
          constantOut = size'(irReg[7:0]);
        end
        opLd: begin
          RW = 1'b1;
          MD = 1'b1;
          DA = irReg[11:10];
          AA = irReg[9:8];
        end
        opSt: begin
          MW = 1'b1;
          AA = irReg[9:8];
          BA = irReg[7:6];
        end
        opJmp: begin
          AA = irReg[9:8];
        end
        opBrz, opBrn: begin
          AA = irReg[9:8];
          FS = FS_PASSA;
        end
        default: ;
      endcase
    end
    // A reset landing mid-EXEC must not let the datapath or memory commit.
    if (reset) begin
      RW = 1'b0;
      MW = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= FETCH;
      pcReg     <= '0;
      irReg     <= '0;
      haltedReg <= 1'b0;
    end else begin
      case (stateReg)
        FETCH: begin
          if (instrReady) begin
            irReg    <= instrIn;
            pcReg    <= pcReg + 1'b1;
            stateReg <= EXEC;
          end
        end
        EXEC: begin
          stateReg <= FETCH;
          case (opcode)
            opJmp: pcReg <= jumpAddress;
            opBrz: if (Z) pcReg <= branchTarget;
            opBrn: if (N) pcReg <= branchTarget;
            opHalt: begin
              stateReg  <= HALT;
              haltedReg <= 1'b1;
            end
            default: ;
          endcase
        end
        HALT: stateReg <= HALT;
        default: stateReg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  instrAddress;
  logic [15:0] instrIn;
  logic        instrReady;
  logic        V, C, N, Z;
  logic [7:0]  jumpAddress;
  logic        RW;
  logic [1:0]  DA, AA, BA;
  logic        MB, MD;
  logic [3:0]  FS;
  logic [7:0]  constantOut;
  logic        MW;
  logic        halted;

  control_sequencer #(.size(8)) dut (
    .clk(clk), .reset(reset), .instrAddress(instrAddress),
    .instrIn(instrIn), .instrReady(instrReady),
    .V(V), .C(C), .N(N), .Z(Z), .jumpAddress(jumpAddress),
    .RW(RW), .DA(DA), .AA(AA), .BA(BA), .MB(MB), .MD(MD), .FS(FS),
    .constantOut(constantOut), .MW(MW), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: one instruction (stall cycles, fetch, exec); kind 1: one idle cycle
  typedef struct {
    int          kind;
    int          addr;
    logic [15:0] instr;
    logic [21:0] ctrl;
    bit          rstExec;
    bit          expHalted;
  } expT;

  expT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  pcModel = 0;
  bit  pending = 0;
  expT cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what one instruction at address pc should drive in
  // EXEC, and where the following fetch happens.
  task automatic model(input logic [15:0] ins, input int pc, input logic n, input logic z,
                       input int jmp, output logic [21:0] ctrl, output int nextPc);
    int opc, imm, simm;
    logic rw, mb, md, mw;
    logic [1:0] da, aa, ba;
    logic [3:0] fs;
    logic [7:0] k;
    opc = int'(ins[15:12]);
    imm = int'(ins[7:0]);
    simm = (imm >= 128) ? imm - 256 : imm;
    rw = 0; mb = 0; md = 0; mw = 0; da = 0; aa = 0; ba = 0; fs = 0; k = 0;
    nextPc = (pc + 1) % 256;
    case (opc)
      1: begin rw = 1; da = ins[11:10]; aa = ins[9:8]; ba = ins[7:6]; fs = ins[3:0]; end
      2: begin rw = 1; mb = 1; fs = 4'b0010; k = ins[7:0]; da = ins[11:10]; aa = ins[9:8]; end
      3: begin rw = 1; mb = 1; fs = 4'b1100; k = ins[7:0]; da = ins[11:10]; end
      4: begin rw = 1; md = 1; da = ins[11:10]; aa = ins[9:8]; end
      5: begin mw = 1; aa = ins[9:8]; ba = ins[7:6]; end
      6: begin aa = ins[9:8]; nextPc = jmp; end
      7: begin aa = ins[9:8]; if (z) nextPc = (pc + 1 + simm + 256) % 256; end
      9: begin aa = ins[9:8]; if (n) nextPc = (pc + 1 + simm + 256) % 256; end
      default: ;
    endcase
    ctrl = {rw, da, aa, ba, mb, md, fs, k, mw};
  endtask

  task automatic randomNoise();
    instrIn     = 16'($urandom);
    {V, C, N, Z} = 4'($urandom);
    jumpAddress = 8'($urandom);
  endtask

  // flags is {V,C,N,Z} presented during EXEC
  task automatic runInstr(input logic [15:0] ins, input int stall, input logic [3:0] flags,
                          input logic [7:0] jmp, input bit rstExec);
    expT e;
    int nextPc;
    e.kind = 0; e.addr = pcModel; e.instr = ins; e.rstExec = rstExec; e.expHalted = 0;
    model(ins, pcModel, flags[1], flags[0], int'(jmp), e.ctrl, nextPc);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      reset = 0; instrReady = 0; randomNoise();
      if (i == 0) expQ.push_back(e);
    end
    @(posedge clk); #1;
    reset = 0; instrReady = 1; randomNoise(); instrIn = ins;
    if (stall == 0) expQ.push_back(e);
    @(posedge clk); #1;
    instrReady = 0; instrIn = 16'($urandom);
    {V, C, N, Z} = flags; jumpAddress = jmp;
    reset = rstExec;
    pcModel = rstExec ? 0 : nextPc;
  endtask

  task automatic idleCycles(input int count, input bit rst, input bit readyRand,
                            input bit expHalted, input int addr);
    expT e;
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      reset = rst;
      instrReady = readyRand ? 1'($urandom) : 1'b0;
      randomNoise();
      e.kind = 1; e.addr = addr; e.instr = '0; e.ctrl = '0; e.rstExec = 0; e.expHalted = expHalted;
      expQ.push_back(e);
    end
  endtask

  // Monitor: consumes one expectation per observed cycle
  initial begin
    logic [21:0] ctrlAct;
    expT e;
    forever begin
      @(negedge clk);
      ctrlAct = {RW, DA, AA, BA, MB, MD, FS, constantOut, MW};
      if (pending) begin
        if (cur.rstExec) begin
          check("exec_rw_under_reset", 32'(RW), 32'd0);
          check("exec_mw_under_reset", 32'(MW), 32'd0);
        end else begin
          check("exec_ctrl", 32'(ctrlAct), 32'(cur.ctrl));
          check("exec_halted", 32'(halted), 32'd0);
        end
        $display("txn addr=%02h instr=%04h ctrl=%06h exp=%06h rst=%0d",
                 cur.addr, cur.instr, ctrlAct, cur.ctrl, cur.rstExec);
        pending = 0;
      end else if (expQ.size() > 0) begin
        e = expQ[0];
        check("fetch_addr", 32'(instrAddress), 32'(e.addr));
        check("idle_ctrl", 32'(ctrlAct), 32'd0);
        check("halted", 32'(halted), 32'(e.expHalted));
        if (e.kind == 1) begin
          void'(expQ.pop_front());
        end else if (instrReady) begin
          void'(expQ.pop_front());
          cur = e;
          pending = 1;
        end
      end
    end
  end

  initial begin
    logic [15:0] ins;
    int drained;
    reset = 1; instrReady = 0; instrIn = 0; V = 0; C = 0; N = 0; Z = 0; jumpAddress = 0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    idleCycles(1, 0, 0, 0, 0);
    pcModel = 0;
    // LDI R1,0x05 with no stall, then OPR behind a 3-cycle stall
    runInstr(16'h3405, 0, 4'h0, 8'h00, 0);
    runInstr(16'h1A47, 3, 4'hF, 8'h00, 0);
    // BRZ taken and not taken from 0x10, offset -2
    runInstr(16'h6100, 0, 4'h0, 8'h10, 0);
    runInstr(16'h71FE, 0, 4'h1, 8'h00, 0);
    runInstr(16'h6100, 1, 4'h0, 8'h10, 0);
    runInstr(16'h71FE, 0, 4'h2, 8'h00, 0);
    // BRN taken forward
    runInstr(16'h9203, 0, 4'h2, 8'h00, 0);
    // PC wrap 0xFF -> 0x00, then JMP 0x42
    runInstr(16'h6100, 0, 4'h0, 8'hFF, 0);
    runInstr(16'h0000, 0, 4'h0, 8'h00, 0);
    runInstr(16'h6200, 0, 4'h0, 8'h42, 0);
    // ST and LD
    runInstr(16'h5180, 0, 4'h0, 8'h00, 0);
    runInstr(16'h4900, 2, 4'h0, 8'h00, 0);
    runInstr(16'h2E7F, 0, 4'h0, 8'h00, 0);
    // randomized program
    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'd8) ins[15:12] = 4'd0;
      runInstr(ins, int'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 0);
    end
    // reset during OPR EXEC, then recovery from address 0
    runInstr(16'h1E4F, 0, 4'h0, 8'h00, 1);
    runInstr(16'h3705, 0, 4'h0, 8'h00, 0);
    // HALT: frozen for 20 cycles with ready toggling, left only by reset
    runInstr(16'h8000, 1, 4'h0, 8'h00, 0);
    idleCycles(20, 0, 1, 1, pcModel);
    idleCycles(1, 1, 1, 1, pcModel);
    idleCycles(1, 0, 0, 0, 0);
    pcModel = 0;
    runInstr(16'h1000, 0, 4'h0, 8'h00, 0);
    runInstr(16'h0000, 0, 4'h0, 8'h00, 0);
    @(posedge clk); #1;
    instrReady = 0;
    drained = 0;
    for (int i = 0; i < 50; i++) begin
      if (expQ.size() == 0 && !pending) begin
        drained = 1;
        break;
      end
      @(posedge clk);
    end
    check("scoreboard_drained", 32'(drained), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
